// File: rtl/rst_pkg.sv
// -----------------------------------------------------------------------------
// rst_pkg
// Shared definitions for the reset-sequencing blocks.
//   - FSM state encodings used by rst_seq_ctrl (and later reset blocks).
//   - max_int helper used to size the shared hold/gap counters.
// No ports (package).
// -----------------------------------------------------------------------------
package rst_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_HOLD    = 2'd0;
  localparam logic [STATE_W-1:0] ST_RELEASE = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE    = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync_core.sv
// -----------------------------------------------------------------------------
// rst_sync_core
// Reset synchroniser: asynchronous assertion, synchronous release.
// A chain of NUM_STAGES flops is cleared asynchronously by RST and shifts in
// a 1 on every rising edge once RST is high; the last stage is rst_ok.
// Ports:
//   CLK    in   clock
//   RST    in   asynchronous active-low reset
//   rst_ok out  synchronised "reset released" indication (active-high)
// -----------------------------------------------------------------------------
module rst_sync_core #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic rst_ok
);

  logic [NUM_STAGES-1:0] sync_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], 1'b1};
    end
  end

  assign rst_ok = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
// Reset sequencer: after the synchronised release of RST (or the end of a
// soft-reset request) all channel resets are held low for HOLD_CYCLES edges,
// then released one at a time, GAP_CYCLES edges apart, in bit order.
// RST_DONE rises on the edge that releases the last channel.
// Ports:
//   CLK         in   clock, all state on the rising edge
//   RST         in   asynchronous active-low reset (synchronous release)
//   SW_RST_REQ  in   synchronous active-high soft-reset request (level)
//   SYNC_RST    out  per-channel active-low resets, NUM_CH bits, registered
//   RST_DONE    out  high once every SYNC_RST bit is released, registered
// -----------------------------------------------------------------------------
module rst_seq_ctrl
  import rst_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW_RST_REQ,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES)) + 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic rst_ok;

  logic [STATE_W-1:0] state_q,    state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   gap_cnt_q,  gap_cnt_d;
  logic [IDX_W-1:0]   ch_idx_q,   ch_idx_d;
  logic [NUM_CH-1:0]  sync_rst_q, sync_rst_d;
  logic               rst_done_q, rst_done_d;

  rst_sync_core #(
    .NUM_STAGES (NUM_STAGES)
  ) u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .rst_ok (rst_ok)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ch_idx_d   = ch_idx_q;
    sync_rst_d = sync_rst_q;
    rst_done_d = rst_done_q;

    // Nothing advances until the synchronised release; everything is already
    // in its cleared state while rst_ok is low, so soft requests are moot.
    if (rst_ok) begin
      if (SW_RST_REQ) begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
        gap_cnt_d  = '0;
        ch_idx_d   = '0;
        sync_rst_d = '0;
        rst_done_d = 1'b0;
      end else begin
        case (state_q)
          ST_HOLD: begin
            // Channel 0 is released on the edge that completes the hold count.
            if (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
              hold_cnt_d    = '0;
              gap_cnt_d     = '0;
              sync_rst_d[0] = 1'b1;
              if (NUM_CH == 1) begin
                state_d    = ST_DONE;
                rst_done_d = 1'b1;
              end else begin
                state_d  = ST_RELEASE;
                ch_idx_d = IDX_W'(1);
              end
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end

          ST_RELEASE: begin
            // ch_idx_q names the next channel to release.
            if (gap_cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
              gap_cnt_d  = '0;
              sync_rst_d = sync_rst_q | (NUM_CH'(1) << ch_idx_q);
              if (ch_idx_q == IDX_W'(NUM_CH - 1)) begin
                state_d    = ST_DONE;
                rst_done_d = 1'b1;
              end else begin
                ch_idx_d = ch_idx_q + 1'b1;
              end
            end else begin
              gap_cnt_d = gap_cnt_q + 1'b1;
            end
          end

          ST_DONE: begin
            state_d = ST_DONE;
          end

          default: begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
            gap_cnt_d  = '0;
            ch_idx_d   = '0;
            sync_rst_d = '0;
            rst_done_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      ch_idx_q   <= '0;
      sync_rst_q <= '0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ch_idx_q   <= ch_idx_d;
      sync_rst_q <= sync_rst_d;
      rst_done_q <= rst_done_d;
    end
  end

  assign SYNC_RST = sync_rst_q;
  assign RST_DONE = rst_done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctrl
// Self-checking bench for rst_seq_ctrl with NUM_STAGES=2, NUM_CH=3,
// HOLD_CYCLES=4, GAP_CYCLES=3. Inputs change on the falling edge, outputs are
// compared on the following falling edge against an expectation queued at the
// rising edge. Expectations come either from a constant vector table or from a
// timing model: bit i is released at start + HOLD + i*GAP, where start is the
// edge rst_ok first reads high or the last edge a soft request was accepted.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

  localparam int NS   = 2;
  localparam int NCH  = 3;
  localparam int HOLD = 4;
  localparam int GAP  = 3;
  localparam int BIG  = 1 << 30;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           SW_RST_REQ = 1'b0;
  logic [NCH-1:0] SYNC_RST;
  logic           RST_DONE;

  rst_seq_ctrl #(
    .NUM_STAGES  (NS),
    .NUM_CH      (NCH),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SW_RST_REQ (SW_RST_REQ),
    .SYNC_RST   (SYNC_RST),
    .RST_DONE   (RST_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit             rst;
    bit             sw;
    logic [NCH-1:0] sync;
    bit             done;
  } vec_t;

  typedef struct {
    string          name;
    int             edge_no;
    logic [NCH-1:0] sync;
    bit             done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // timing model state
  int edge_n       = 0;
  bit rst_low_seen = 1'b1;
  int ok_edge      = BIG;
  int start_edge   = BIG;

  task automatic add_vec(input bit r, input bit s, input logic [NCH-1:0] y, input bit d);
    vec_t v;
    v.rst = r; v.sw = s; v.sync = y; v.done = d;
    vecs.push_back(v);
  endtask

  task automatic model_edge(input bit r, input bit s,
                            output logic [NCH-1:0] es, output bit ed);
    edge_n++;
    if (!r) begin
      rst_low_seen = 1'b1;
      ok_edge      = BIG;
      start_edge   = BIG;
    end else if (rst_low_seen) begin
      rst_low_seen = 1'b0;
      ok_edge      = edge_n + NS - 1;
      start_edge   = ok_edge;
    end else if (s && edge_n > ok_edge) begin
      start_edge = edge_n;
    end
    for (int i = 0; i < NCH; i++)
      es[i] = r && (edge_n >= start_edge + HOLD + i * GAP);
    ed = &es;
  endtask

  task automatic check_one();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: no expectation queued at time %0t", $time);
    end else begin
      e = sb.pop_front();
      if (SYNC_RST !== e.sync || RST_DONE !== e.done) begin
        failures++;
        $display("FAIL %s: edge %0d got SYNC_RST=%b RST_DONE=%b expected SYNC_RST=%b RST_DONE=%b",
                 e.name, e.edge_no, SYNC_RST, RST_DONE, e.sync, e.done);
      end else begin
        $display("%s: edge %0d SYNC_RST=%b RST_DONE=%b ok", e.name, e.edge_no, SYNC_RST, RST_DONE);
      end
    end
  endtask

  // One clock: drive inputs, queue the expectation at the rising edge,
  // compare at the falling edge.
  task automatic step(input string name, input bit r, input bit s, input bit use_tab,
                      input logic [NCH-1:0] tsync, input bit tdone);
    exp_t           e;
    logic [NCH-1:0] ms;
    bit             md;
    RST        = r;
    SW_RST_REQ = s;
    @(posedge CLK);
    model_edge(r, s, ms, md);
    e.name    = name;
    e.edge_no = edge_n;
    e.sync    = use_tab ? tsync : ms;
    e.done    = use_tab ? tdone : md;
    sb.push_back(e);
    @(negedge CLK);
    check_one();
  endtask

  task automatic run(input string name, input bit r, input bit s);
    step(name, r, s, 1'b0, '0, 1'b0);
  endtask

  // Short RST low pulse entirely between two rising edges.
  task automatic async_pulse(input string name);
    checks++;
    if (SYNC_RST !== 3'b011) begin
      failures++;
      $display("FAIL %s_pre: got SYNC_RST=%b expected SYNC_RST=011", name, SYNC_RST);
    end
    RST = 1'b0;
    #1;
    checks++;
    if (SYNC_RST !== 3'b000 || RST_DONE !== 1'b0) begin
      failures++;
      $display("FAIL %s: got SYNC_RST=%b RST_DONE=%b expected SYNC_RST=000 RST_DONE=0",
               name, SYNC_RST, RST_DONE);
    end else begin
      $display("%s: async clear SYNC_RST=%b RST_DONE=%b ok", name, SYNC_RST, RST_DONE);
    end
    rst_low_seen = 1'b1;
    #1;
    RST = 1'b1;
  endtask

  initial begin
    // Power-on vectors: two edges in reset, then RST high before edge 1.
    add_vec(0, 0, 3'b000, 0);
    add_vec(0, 0, 3'b000, 0);
    for (int k = 1; k <= 5; k++) add_vec(1, 0, 3'b000, 0);   // edges 1..5
    for (int k = 6; k <= 8; k++) add_vec(1, 0, 3'b001, 0);   // edges 6..8
    for (int k = 9; k <= 11; k++) add_vec(1, 0, 3'b011, 0);  // edges 9..11
    add_vec(1, 0, 3'b111, 1);                                // edge 12
    add_vec(1, 0, 3'b111, 1);                                // edge 13

    @(negedge CLK);
    foreach (vecs[k]) step("power_on", vecs[k].rst, vecs[k].sw, 1'b1, vecs[k].sync, vecs[k].done);

    // One-cycle soft reset from DONE.
    run("soft_pulse_done", 1, 1);
    repeat (12) run("soft_pulse_done", 1, 0);

    // Soft reset held for 10 cycles from DONE.
    repeat (10) run("soft_held", 1, 1);
    repeat (12) run("soft_held", 1, 0);

    // Soft reset during RELEASE, sampled at edge 8 after power-on.
    repeat (2) run("soft_release", 0, 0);
    repeat (7) run("soft_release", 1, 0);
    run("soft_release", 1, 1);
    repeat (12) run("soft_release", 1, 0);

    // RST pulse between edges 10 and 11.
    repeat (2) run("rst_mid", 0, 0);
    repeat (10) run("rst_mid", 1, 0);
    async_pulse("rst_mid_async");
    repeat (13) run("rst_mid", 1, 0);

    // Soft request while RST is low, dropped before release.
    repeat (3) run("sw_in_rst", 0, 1);
    run("sw_in_rst", 0, 0);
    repeat (13) run("sw_in_rst", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
